// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the EX->MEM pipeline register: default widths,
// control-field bit positions, the default-width payload view and the
// skid-buffer state encoding.
package ex_mem_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int WB_W_DEF   = 2;
  localparam int MEM_W_DEF  = 2;

  localparam int WB_REGWRITE_BIT = 0;
  localparam int MEM_READ_BIT    = 0;
  localparam int MEM_WRITE_BIT   = 1;

  // Payload layout at the default widths; the top packs fields in this order.
  typedef struct packed {
    logic [WB_W_DEF-1:0]   wb;
    logic [MEM_W_DEF-1:0]  mem;
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] rtdata;
    logic [ADDR_W_DEF-1:0] writeaddr;
  } ex_mem_payload_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } skid_state_t;

  function automatic int payload_width(input int data_w, input int addr_w,
                                       input int wb_w, input int mem_w);
    return wb_w + mem_w + 2 * data_w + addr_w;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_skid_buf.sv
// Generic 2-entry skid buffer with a fully registered upstream ready.
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_EMPTY | no entry held, out_valid_o=0, in_ready_o=1
//   ST_FULL  | main slot valid and presented, in_ready_o=1
//   ST_SKID  | main and skid valid, skid waits behind main, in_ready_o=0
//
// Because in_ready_o is derived from the next state and registered, the
// downstream ready never reaches the upstream ready combinationally.
module pipe_skid_buf
  import ex_mem_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  skid_state_t  state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_ready_q, in_ready_d;
  logic         accept, emit;

  assign out_valid_o = (state_q != ST_EMPTY);
  assign in_ready_o  = in_ready_q;
  assign out_data_o  = main_q;
  assign accept      = in_valid_i & in_ready_q;
  assign emit        = out_valid_o & out_ready_i;

  // Next-state and slot loading; flush wins over any same-cycle accept.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          main_d  = in_data_i;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (accept && emit) begin
          main_d = in_data_i;
        end else if (accept) begin
          skid_d  = in_data_i;
          state_d = ST_SKID;
        end else if (emit) begin
          state_d = ST_EMPTY;
        end
      end
      ST_SKID: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush_i) begin
      state_d = ST_EMPTY;
    end
    in_ready_d = (state_d != ST_SKID);
  end

  // State, slots and registered upstream ready.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// Elastic EX->MEM pipeline register. Packs the EX outputs into a skid
// buffer, gates WB/MEM control on bubbles and, when EX_MEM_FWD_EN is
// defined, exposes a forwarding tap taken from the main slot.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int WB_W   = WB_W_DEF,
  parameter int MEM_W  = MEM_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [MEM_W-1:0]  mem_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] rtdata_i,
  input  logic [ADDR_W-1:0] writeaddr_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [MEM_W-1:0]  mem_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] rtdata_o,
  output logic [ADDR_W-1:0] writeaddr_o
`ifdef EX_MEM_FWD_EN
  ,
  output logic              fwd_we_o,
  output logic [ADDR_W-1:0] fwd_addr_o,
  output logic [DATA_W-1:0] fwd_data_o
`endif
);

  localparam int PAYLOAD_W = payload_width(DATA_W, ADDR_W, WB_W, MEM_W);

  logic [PAYLOAD_W-1:0] in_payload;
  logic [PAYLOAD_W-1:0] out_payload;
  logic [WB_W-1:0]      wb_main;
  logic [MEM_W-1:0]     mem_main;

  assign in_payload = {wb_i, mem_i, result_i, rtdata_i, writeaddr_i};
  assign {wb_main, mem_main, result_o, rtdata_o, writeaddr_o} = out_payload;

  pipe_skid_buf #(
    .W (PAYLOAD_W)
  ) u_skid (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_payload),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_payload)
  );

  // Control is forced to zero on bubbles so stale RegWrite/MemWrite never fire.
  always_comb begin
    wb_o  = '0;
    mem_o = '0;
    if (out_valid_o) begin
      wb_o  = wb_main;
      mem_o = mem_main;
    end
  end

`ifdef EX_MEM_FWD_EN
  // Forwarding tap; writes to register 0 are never forwarded.
  always_comb begin
    fwd_we_o   = out_valid_o & wb_o[WB_REGWRITE_BIT] & (writeaddr_o != '0);
    fwd_addr_o = writeaddr_o;
    fwd_data_o = result_o;
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Self-checking bench for ex_mem_pipe: directed scenarios plus a randomized
// run compared against a transaction-level FIFO model (capacity two).
module tb_ex_mem_pipe;
  import ex_mem_pipe_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [1:0]  wb_i = '0;
  logic [1:0]  mem_i = '0;
  logic [31:0] result_i = '0;
  logic [31:0] rtdata_i = '0;
  logic [4:0]  writeaddr_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [1:0]  wb_o;
  logic [1:0]  mem_o;
  logic [31:0] result_o;
  logic [31:0] rtdata_o;
  logic [4:0]  writeaddr_o;
`ifdef EX_MEM_FWD_EN
  logic        fwd_we_o;
  logic [4:0]  fwd_addr_o;
  logic [31:0] fwd_data_o;
`endif

  int checks = 0;
  int errors = 0;

  ex_mem_payload_t mq[$];

  always #5 clk_i = ~clk_i;

  ex_mem_pipe dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .wb_i        (wb_i),
    .mem_i       (mem_i),
    .result_i    (result_i),
    .rtdata_i    (rtdata_i),
    .writeaddr_i (writeaddr_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .wb_o        (wb_o),
    .mem_o       (mem_o),
    .result_o    (result_o),
    .rtdata_o    (rtdata_o),
    .writeaddr_o (writeaddr_o)
`ifdef EX_MEM_FWD_EN
    ,
    .fwd_we_o    (fwd_we_o),
    .fwd_addr_o  (fwd_addr_o),
    .fwd_data_o  (fwd_data_o)
`endif
  );

  function automatic ex_mem_payload_t mk(input logic [1:0] wb, input logic [1:0] mem,
                                         input logic [31:0] res, input logic [4:0] wa);
    ex_mem_payload_t p;
    p.wb = wb; p.mem = mem; p.result = res; p.rtdata = ~res; p.writeaddr = wa;
    return p;
  endfunction

  function automatic ex_mem_payload_t rand_payload();
    ex_mem_payload_t p;
    p.wb = 2'($urandom); p.mem = 2'($urandom); p.result = $urandom;
    p.rtdata = $urandom; p.writeaddr = 5'($urandom);
    return p;
  endfunction

  // Drive one cycle of inputs, cross the rising edge, update the FIFO model.
  task automatic tick(input logic v, input logic r, input logic f, input ex_mem_payload_t p);
    bit acc, emt;
    in_valid_i = v; out_ready_i = r; flush_i = f;
    wb_i = p.wb; mem_i = p.mem; result_i = p.result; rtdata_i = p.rtdata;
    writeaddr_i = p.writeaddr;
    acc = v && (mq.size() < 2);
    emt = r && (mq.size() > 0);
    @(posedge clk_i);
    #1;
    if (f) mq.delete();
    else begin
      if (emt) void'(mq.pop_front());
      if (acc) mq.push_back(p);
    end
    in_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #3;
    rst_n_i = 1'b1;
    mq.delete();
    @(negedge clk_i);
    checks++;
    if (in_ready_o !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid_o); end
    checks++;
    if (wb_o !== 2'b00 || mem_o !== 2'b00) begin
      errors++; $display("FAIL reset_ctrl got wb=%b mem=%b exp 00/00", wb_o, mem_o);
    end
    checks++;
    if (result_o !== 32'h0 || writeaddr_o !== 5'h0) begin
      errors++; $display("FAIL reset_payload got result=%h addr=%h exp 0/0", result_o, writeaddr_o);
    end
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 3; i++) begin
      tick(1'b1, 1'b1, 1'b0, mk(2'b01, 2'b00, 32'(i * 16), 5'(i)));
      checks++;
      if (out_valid_o !== 1'b1 || result_o !== 32'(i * 16) || writeaddr_o !== 5'(i)) begin
        errors++;
        $display("FAIL stream_%0d got v=%b res=%h addr=%0d exp v=1 res=%h addr=%0d",
                 i, out_valid_o, result_o, writeaddr_o, 32'(i * 16), i);
      end
      checks++;
      if (in_ready_o !== 1'b1) begin errors++; $display("FAIL stream_ready_%0d got=%b exp=1", i, in_ready_o); end
    end
    tick(1'b0, 1'b1, 1'b0, mk(2'b00, 2'b00, 32'h0, 5'h0));
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL stream_drain got v=%b exp=0", out_valid_o); end
  endtask

  task automatic test_back_pressure();
    tick(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b00, 32'hAAAA, 5'd10));
    checks++;
    if (out_valid_o !== 1'b1 || result_o !== 32'hAAAA || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_A got v=%b res=%h rdy=%b exp 1/aaaa/1", out_valid_o, result_o, in_ready_o);
    end
    tick(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b00, 32'hBBBB, 5'd11));
    checks++;
    if (in_ready_o !== 1'b0 || result_o !== 32'hAAAA) begin
      errors++; $display("FAIL bp_skid got rdy=%b res=%h exp 0/aaaa", in_ready_o, result_o);
    end
    tick(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b00, 32'hDEAD, 5'd12));
    checks++;
    if (in_ready_o !== 1'b0 || result_o !== 32'hAAAA || rtdata_o !== ~32'hAAAA) begin
      errors++; $display("FAIL bp_hold got rdy=%b res=%h rt=%h exp 0/aaaa/%h", in_ready_o, result_o, rtdata_o, ~32'hAAAA);
    end
    tick(1'b0, 1'b1, 1'b0, mk(2'b00, 2'b00, 32'h0, 5'h0));
    checks++;
    if (out_valid_o !== 1'b1 || result_o !== 32'hBBBB || writeaddr_o !== 5'd11 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL bp_B got v=%b res=%h addr=%0d rdy=%b exp 1/bbbb/11/1",
                         out_valid_o, result_o, writeaddr_o, in_ready_o);
    end
    tick(1'b0, 1'b1, 1'b0, mk(2'b00, 2'b00, 32'h0, 5'h0));
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL bp_drain got v=%b exp=0", out_valid_o); end
  endtask

  task automatic test_flush();
    tick(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b10, 32'h1111, 5'd1));
    tick(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b10, 32'h2222, 5'd2));
    checks++;
    if (in_ready_o !== 1'b0) begin errors++; $display("FAIL flush_pre_skid got rdy=%b exp=0", in_ready_o); end
    tick(1'b1, 1'b0, 1'b1, mk(2'b01, 2'b10, 32'hCCCC, 5'd3));
    checks++;
    if (out_valid_o !== 1'b0 || wb_o !== 2'b00 || mem_o !== 2'b00 || in_ready_o !== 1'b1) begin
      errors++; $display("FAIL flush_skid got v=%b wb=%b mem=%b rdy=%b exp 0/00/00/1",
                         out_valid_o, wb_o, mem_o, in_ready_o);
    end
    // Flush while FULL with a simultaneous accept: the new entry is dropped.
    tick(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b01, 32'h3333, 5'd4));
    tick(1'b1, 1'b0, 1'b1, mk(2'b01, 2'b01, 32'hCCCC, 5'd5));
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b1, 1'b0, mk(2'b00, 2'b00, 32'h0, 5'h0));
      checks++;
      if (out_valid_o !== 1'b0) begin
        errors++; $display("FAIL flush_no_emit_%0d got v=%b res=%h exp v=0", i, out_valid_o, result_o);
      end
    end
  endtask

  task automatic test_gating();
    tick(1'b1, 1'b1, 1'b0, mk(2'b01, 2'b10, 32'h5555, 5'd6));
    checks++;
    if (wb_o !== 2'b01 || mem_o !== 2'b10 || mem_o[MEM_WRITE_BIT] !== 1'b1) begin
      errors++; $display("FAIL gate_live got wb=%b mem=%b exp 01/10", wb_o, mem_o);
    end
    tick(1'b1, 1'b1, 1'b0, mk(2'b11, 2'b01, 32'h6666, 5'd7));
    checks++;
    if (wb_o[WB_REGWRITE_BIT] !== 1'b1 || mem_o[MEM_READ_BIT] !== 1'b1 || wb_o !== 2'b11) begin
      errors++; $display("FAIL gate_read got wb=%b mem=%b exp 11/01", wb_o, mem_o);
    end
    tick(1'b0, 1'b1, 1'b0, mk(2'b00, 2'b00, 32'h0, 5'h0));
    checks++;
    if (out_valid_o !== 1'b0 || wb_o !== 2'b00 || mem_o !== 2'b00) begin
      errors++; $display("FAIL gate_bubble got v=%b wb=%b mem=%b exp 0/00/00", out_valid_o, wb_o, mem_o);
    end
  endtask

`ifdef EX_MEM_FWD_EN
  task automatic test_forwarding();
    tick(1'b1, 1'b1, 1'b0, mk(2'b01, 2'b00, 32'h9999, 5'd0));
    checks++;
    if (fwd_we_o !== 1'b0) begin errors++; $display("FAIL fwd_r0 got we=%b exp=0", fwd_we_o); end
    tick(1'b1, 1'b1, 1'b0, mk(2'b01, 2'b00, 32'h1234, 5'd7));
    checks++;
    if (fwd_we_o !== 1'b1 || fwd_addr_o !== 5'd7 || fwd_data_o !== 32'h1234) begin
      errors++; $display("FAIL fwd_r7 got we=%b addr=%0d data=%h exp 1/7/1234", fwd_we_o, fwd_addr_o, fwd_data_o);
    end
    tick(1'b0, 1'b1, 1'b0, mk(2'b00, 2'b00, 32'h0, 5'h0));
    checks++;
    if (fwd_we_o !== 1'b0) begin errors++; $display("FAIL fwd_bubble got we=%b exp=0", fwd_we_o); end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      tick(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0), rand_payload());
      checks++;
      if (out_valid_o !== (mq.size() > 0) || in_ready_o !== (mq.size() < 2)) begin
        errors++; $display("FAIL rand_hs_%0d got v=%b rdy=%b exp v=%b rdy=%b",
                           n, out_valid_o, in_ready_o, mq.size() > 0, mq.size() < 2);
      end
      checks++;
      if (mq.size() > 0) begin
        if (wb_o !== mq[0].wb || mem_o !== mq[0].mem || result_o !== mq[0].result ||
            rtdata_o !== mq[0].rtdata || writeaddr_o !== mq[0].writeaddr) begin
          errors++; $display("FAIL rand_data_%0d got %b/%b/%h/%h/%0d exp %b/%b/%h/%h/%0d", n,
                             wb_o, mem_o, result_o, rtdata_o, writeaddr_o, mq[0].wb, mq[0].mem,
                             mq[0].result, mq[0].rtdata, mq[0].writeaddr);
        end
      end else if (wb_o !== 2'b00 || mem_o !== 2'b00) begin
        errors++; $display("FAIL rand_gate_%0d got wb=%b mem=%b exp 00/00", n, wb_o, mem_o);
      end
    end
  endtask

  task automatic test_async_reset();
    tick(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b10, 32'h7777, 5'd8));
    tick(1'b1, 1'b0, 1'b0, mk(2'b01, 2'b10, 32'h8888, 5'd9));
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    mq.delete();
    checks++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || result_o !== 32'h0 || wb_o !== 2'b00) begin
      errors++; $display("FAIL async_reset got v=%b rdy=%b res=%h wb=%b exp 0/1/0/00",
                         out_valid_o, in_ready_o, result_o, wb_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick(1'b0, 1'b1, 1'b0, mk(2'b00, 2'b00, 32'h0, 5'h0));
    checks++;
    if (out_valid_o !== 1'b0) begin errors++; $display("FAIL async_lost got v=%b exp=0", out_valid_o); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_back_pressure();
    test_flush();
    test_gating();
`ifdef EX_MEM_FWD_EN
    test_forwarding();
`endif
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
